// File: rtl/instr_sequencer.sv
// Multicycle control FSM for the RISC-V simple datapath: fetch, decode, execute,
// memory and write-back, with memory handshakes, halt/error reporting and a retire counter.
module instr_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_src,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_ALU    = 2'd0,
        C_LOAD   = 2'd1,
        C_STORE  = 2'd2,
        C_BRANCH = 2'd3
    } cls_t;

    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state, w_next;
    cls_t              r_cls, w_cls_next;
    logic              r_err;
    logic [15:0]       r_to_cnt;
    logic [CNT_W-1:0]  r_count;
    logic              w_err_set, w_to_clr, w_to_inc;

    // Handshake: a request (imem_req/dmem_req) stays high until its ack is seen; the
    // transfer completes in the ack cycle. Acks seen outside the request state are ignored.
    always_comb begin
        w_next     = r_state;
        w_cls_next = r_cls;
        w_err_set  = 1'b0;
        w_to_clr   = 1'b0;
        w_to_inc   = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_FETCH;
                    w_to_clr = 1'b1;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next    = S_HALT;
                    w_err_set = 1'b1;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
                case (opcode)
                    OP_R, OP_I: w_cls_next = C_ALU;
                    OP_LOAD:    w_cls_next = C_LOAD;
                    OP_STORE:   w_cls_next = C_STORE;
                    OP_BRANCH:  w_cls_next = C_BRANCH;
                    OP_SYSTEM:  w_next     = S_HALT;
                    default: begin
                        w_next    = S_HALT;
                        w_err_set = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (r_cls)
                    C_BRANCH: begin
                        pc_en    = 1'b1;
                        pc_src   = alu_zero;
                        w_next   = S_FETCH;
                        w_to_clr = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        w_next   = S_MEM;
                        w_to_clr = 1'b1;
                    end
                    default: w_next = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == C_STORE);
                if (dmem_ack) begin
                    if (r_cls == C_STORE) begin
                        pc_en    = 1'b1;
                        w_next   = S_FETCH;
                        w_to_clr = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_next    = S_HALT;
                    w_err_set = 1'b1;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                pc_en    = 1'b1;
                w_next   = S_FETCH;
                w_to_clr = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cls    <= C_ALU;
            r_err    <= 1'b0;
            r_to_cnt <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next;
            r_cls   <= w_cls_next;
            if (w_err_set) r_err <= 1'b1;
            if (w_to_clr) r_to_cnt <= '0;
            else if (w_to_inc) r_to_cnt <= r_to_cnt + 16'd1;
            if (pc_en) r_count <= r_count + CNT_W'(1);
        end
    end

    assign halted      = (r_state == S_HALT);
    assign err         = r_err;
    assign instr_count = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a scoreboard of expected retires plus
// cycle-by-cycle handshake checks, and a second instance with a short timeout.
module tb_instr_sequencer;
    localparam int CNT_W = 32;
    localparam int W     = CNT_W + 2;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_SYS = 7'b1110011;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic start = 1'b0, alu_zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_en, pc_src, halted, err;
    logic [CNT_W-1:0] instr_count;
    logic [2:0] dbg_state;

    logic start2 = 1'b0, imem_ack2 = 1'b0, dmem_ack2 = 1'b0;
    logic imem_req2, dmem_req2, dmem_we2, ir_we2, rf_we2, pc_en2, pc_src2, halted2, err2;
    logic [CNT_W-1:0] instr_count2;
    logic [2:0] dbg_state2;

    logic [W-1:0] exp_q[$];
    logic [CNT_W-1:0] m_count = '0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    instr_sequencer #(.TIMEOUT_CYCLES(255), .CNT_W(CNT_W)) u_dut (
        .sysclk(sysclk), .reset(reset), .start(start), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .rf_we(rf_we), .pc_en(pc_en), .pc_src(pc_src),
        .halted(halted), .err(err), .instr_count(instr_count), .o_dbg_state(dbg_state)
    );

    instr_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) u_dut_to (
        .sysclk(sysclk), .reset(reset), .start(start2), .opcode(opcode), .alu_zero(alu_zero),
        .imem_ack(imem_ack2), .dmem_ack(dmem_ack2), .imem_req(imem_req2), .dmem_req(dmem_req2),
        .dmem_we(dmem_we2), .ir_we(ir_we2), .rf_we(rf_we2), .pc_en(pc_en2), .pc_src(pc_src2),
        .halted(halted2), .err(err2), .instr_count(instr_count2), .o_dbg_state(dbg_state2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    // Retire monitor: every pc_en cycle must match the oldest expected retire.
    always @(negedge sysclk) begin
        logic [W-1:0] e;
        if (!reset && pc_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_retire", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("retire", {rf_we, pc_src, instr_count}, e);
            end
        end
        if (!reset) begin
            check_eq("excl_strobes", {(ir_we & (pc_en | rf_we)), (imem_req & dmem_req)}, 2'b00);
        end
    end

    task automatic do_fetch(input int iw);
        for (int i = 0; i <= iw; i++) begin
            imem_ack = (i == iw);
            @(negedge sysclk);
            check_eq("fetch_imem_req", imem_req, 1'b1);
            check_eq("fetch_ir_we", ir_we, (i == iw));
            step();
        end
        imem_ack = 1'b0;
    endtask

    // Precondition: DUT is in FETCH for the current cycle.
    task automatic do_instr(input logic [6:0] op, input int iw, input int dw, input logic az);
        logic legal, is_ld, is_st;
        legal = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_BR);
        is_ld = (op == OP_LD);
        is_st = (op == OP_ST);
        opcode   = op;
        alu_zero = az;
        do_fetch(iw);
        @(negedge sysclk);
        check_eq("decode_quiet", {imem_req, dmem_req, ir_we, rf_we, pc_en}, 5'b0);
        step();
        if (!legal) begin
            @(negedge sysclk);
            check_eq("halt_flag", halted, 1'b1);
            check_eq("halt_err", err, (op != OP_SYS));
            check_eq("halt_no_pc_en", pc_en, 1'b0);
            step();
            return;
        end
        if (op == OP_BR) begin
            exp_q.push_back({1'b0, az, m_count});
            m_count++;
            @(negedge sysclk);
            check_eq("branch_pc_en", pc_en, 1'b1);
            step();
            return;
        end
        @(negedge sysclk);
        check_eq("exec_quiet", {pc_en, rf_we, dmem_req}, 3'b0);
        step();
        if (is_ld || is_st) begin
            for (int i = 0; i <= dw; i++) begin
                dmem_ack = (i == dw);
                if (is_st && i == dw) begin
                    exp_q.push_back({1'b0, 1'b0, m_count});
                    m_count++;
                end
                @(negedge sysclk);
                check_eq("mem_req", {dmem_req, dmem_we, rf_we}, {1'b1, is_st, 1'b0});
                check_eq("mem_pc_en", pc_en, (is_st && i == dw));
                step();
            end
            dmem_ack = 1'b0;
            if (is_st) return;
        end
        exp_q.push_back({1'b1, 1'b0, m_count});
        m_count++;
        @(negedge sysclk);
        check_eq("wb_strobes", {rf_we, pc_en}, 2'b11);
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_count = '0;
        step();
    endtask

    initial begin
        logic [6:0] ops [5];
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};

        // Reset vector, including an asynchronous reset in the middle of a fetch.
        repeat (2) step();
        check_eq("reset_outputs", {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_en, pc_src, halted, err}, 9'b0);
        check_eq("reset_count", instr_count, 0);
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge sysclk);
        check_eq("fetch_started", imem_req, 1'b1);
        step();
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset_req", imem_req, 1'b0);
        check_eq("async_reset_state", dbg_state, 3'd0);
        check_eq("async_reset_count", instr_count, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            check_eq("idle_quiet", {imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_en, pc_src, halted, err}, 9'b0);
            step();
        end

        // Directed instructions, then a random mix with random wait states.
        start = 1'b1;
        step();
        start = 1'b0;
        do_instr(OP_R, 0, 0, 1'b0);
        check_eq("count_after_r", instr_count, 1);
        do_instr(OP_BR, 0, 0, 1'b1);
        do_instr(OP_BR, 0, 0, 1'b0);
        check_eq("count_after_br", instr_count, 3);
        do_instr(OP_I, 2, 0, 1'b0);
        do_instr(OP_LD, 0, 5, 1'b0);
        do_instr(OP_ST, 1, 5, 1'b0);
        check_eq("count_after_mem", instr_count, 6);
        for (int k = 0; k < 12; k++) begin
            do_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end
        check_eq("count_model", instr_count, m_count);

        // ECALL halts cleanly and absorbs later activity.
        do_instr(OP_SYS, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            start    = 1'b1;
            @(negedge sysclk);
            check_eq("ecall_hold", {halted, err, imem_req, dmem_req, ir_we, pc_en}, 6'b100000);
            check_eq("ecall_count_held", instr_count, m_count);
            step();
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        start    = 1'b0;

        // Illegal opcode halts with an error.
        pulse_reset();
        check_eq("reset_clears_halt", {halted, err, instr_count}, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        do_instr(7'b1111111, 1, 0, 1'b0);
        @(negedge sysclk);
        check_eq("illegal_hold", {halted, err}, 2'b11);
        step();

        // Fetch timeout on the short-timeout instance, late acks ignored.
        pulse_reset();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            check_eq("to_req_held", {imem_req2, halted2}, 2'b10);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            imem_ack2 = 1'b1;
            @(negedge sysclk);
            check_eq("to_halt", {halted2, err2, imem_req2, ir_we2}, 4'b1100);
            check_eq("to_quiet", {dmem_req2, dmem_we2, rf_we2, pc_en2, pc_src2}, 5'b0);
            step();
        end
        imem_ack2 = 1'b0;
        check_eq("to_count", instr_count2, 0);

        // An ack in the limit cycle wins over the timeout.
        pulse_reset();
        opcode = OP_R;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ack2 = (i == 3);
            @(negedge sysclk);
            check_eq("limit_req", {imem_req2, ir_we2}, {1'b1, (i == 3)});
            step();
        end
        imem_ack2 = 1'b0;
        @(negedge sysclk);
        check_eq("limit_ack_wins", {halted2, err2, dbg_state2}, {2'b00, 3'd2});
        step();

        check_eq("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
